// File: rtl/step_dir_gen_pkg.sv
// Shared types and defaults for the step/dir pulse generator.
// The timing defaults also feed the bridge driver configuration.
package step_dir_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIR_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_FINISH
    } state_t;

    localparam int DEF_PULSE_WIDTH = 2;
    localparam int DEF_DIR_SETUP   = 3;
    localparam int DEF_DIR_HOLD    = 2;

    // Shortest legal low phase: long enough for both pulse symmetry and dir hold.
    function automatic int min_low(input int pulse_width, input int dir_hold);
        return (pulse_width > dir_hold) ? pulse_width : dir_hold;
    endfunction

endpackage

// File: rtl/step_dir_gen_phase_timer.sv
// Loadable down-counter timing one phase (setup, high or low).
// expired_o is high during the last cycle of the loaded phase length.
module step_phase_timer #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Count holds the cycles left in the phase including the current one.
    assign expired_o = (count_q <= WIDTH'(1));

endmodule

// File: rtl/step_dir_gen.sv
// Step/dir pulse generator: turns (dir, steps, period) commands into step
// pulses with guaranteed pulse width, dir setup and dir hold timing.
module step_dir_gen
    import step_dir_gen_pkg::*;
#(
    parameter int COUNT_BITS  = 32,
    parameter int PERIOD_BITS = 24,
    parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
    parameter int DIR_SETUP   = DEF_DIR_SETUP,
    parameter int DIR_HOLD    = DEF_DIR_HOLD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_dir,
    input  logic [COUNT_BITS-1:0]  cmd_steps,
    input  logic [PERIOD_BITS-1:0] cmd_period,
    input  logic                   abort,
    output logic                   step,
    output logic                   dir,
    output logic                   busy,
    output logic [COUNT_BITS-1:0]  steps_remaining,
    output logic                   done,
    output logic                   aborted
);

    localparam int MIN_LOW = min_low(PULSE_WIDTH, DIR_HOLD);
    localparam int TW      = PERIOD_BITS + 1;

    state_t                  state_q, state_d;
    logic                    dir_q, dir_d;
    logic                    step_q;
    logic                    done_q;
    logic                    aborted_q;
    logic                    abort_q, abort_d;
    logic [COUNT_BITS-1:0]   remaining_q, remaining_d;
    logic [TW-1:0]           low_len_q, low_len_d;
    logic [TW-1:0]           low_cnt_q, low_cnt_d;
    logic [TW-1:0]           cmd_low;
    logic [TW-1:0]           timer_load_value;
    logic                    timer_load;
    logic                    timer_expired;
    logic                    accept;
    logic                    abort_eff;

    assign accept    = cmd_valid && (state_q == ST_IDLE);
    assign abort_eff = abort_q || (abort && (state_q != ST_IDLE));

    // Low time is max(period - pulse width, MIN_LOW), done one bit wider so
    // short periods cannot wrap.
    always_comb begin
        if ({1'b0, cmd_period} > TW'(PULSE_WIDTH + MIN_LOW)) begin
            cmd_low = {1'b0, cmd_period} - TW'(PULSE_WIDTH);
        end else begin
            cmd_low = TW'(MIN_LOW);
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        low_len_d   = low_len_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    low_len_d   = cmd_low;
                    remaining_d = cmd_steps;
                    if (cmd_steps == '0) begin
                        state_d = ST_FINISH;
                    end else if (cmd_dir != dir_q) begin
                        dir_d   = cmd_dir;
                        state_d = ST_DIR_SETUP;
                    end else begin
                        remaining_d = cmd_steps - COUNT_BITS'(1);
                        state_d     = ST_HIGH;
                    end
                end
            end
            ST_DIR_SETUP: begin
                if (abort_eff) begin
                    state_d = ST_FINISH;
                end else if (timer_expired) begin
                    remaining_d = remaining_q - COUNT_BITS'(1);
                    state_d     = ST_HIGH;
                end
            end
            ST_HIGH: begin
                // A started pulse always completes its full width.
                if (timer_expired) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (abort_eff && (low_cnt_q >= TW'(MIN_LOW - 1))) begin
                    state_d = ST_FINISH;
                end else if (timer_expired) begin
                    if (remaining_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        remaining_d = remaining_q - COUNT_BITS'(1);
                        state_d     = ST_HIGH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every state change starts a new phase, so the timer reloads on it.
    always_comb begin
        timer_load       = (state_d != state_q);
        timer_load_value = '0;
        case (state_d)
            ST_DIR_SETUP: timer_load_value = TW'(DIR_SETUP);
            ST_HIGH:      timer_load_value = TW'(PULSE_WIDTH);
            ST_LOW:       timer_load_value = low_len_q;
            default:      timer_load_value = '0;
        endcase
    end

    // Counts low cycles already spent, saturating once an abort could exit.
    always_comb begin
        low_cnt_d = '0;
        if (state_q == ST_LOW) begin
            low_cnt_d = (low_cnt_q < TW'(MIN_LOW)) ? low_cnt_q + TW'(1) : low_cnt_q;
        end
    end

    always_comb begin
        abort_d = abort_q || abort;
        if (state_q == ST_IDLE || state_q == ST_FINISH) begin
            abort_d = 1'b0;
        end
    end

    step_phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .load_i      (timer_load),
        .load_value_i(timer_load_value),
        .expired_o   (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            abort_q     <= 1'b0;
            remaining_q <= '0;
            low_len_q   <= '0;
            low_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            step_q      <= (state_d == ST_HIGH);
            done_q      <= (state_d == ST_FINISH);
            aborted_q   <= (state_d == ST_FINISH) && abort_eff;
            abort_q     <= abort_d;
            remaining_q <= remaining_d;
            low_len_q   <= low_len_d;
            low_cnt_q   <= low_cnt_d;
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign step            = step_q;
    assign dir             = dir_q;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign steps_remaining = remaining_q;

endmodule
